// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - 640x480 raster position counter with pixel strobe and line/frame pulses.
// Optional divide-by-2 pixel strobe from a 2x clock when VGA_CLKDIV_EN is defined.
module vga_timing_counter #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_PULSE  = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_PULSE  = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       pix_en,
  output logic       video_on,
  output logic       line_end,
  output logic       frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_PULSE + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_PULSE + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_range_err
      $error("vga_timing_counter: H_TOTAL and V_TOTAL must fit in 10 bits");
    end
  endgenerate

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);

  logic       tick;
  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] h_next;
  logic [9:0] v_next;

  always_comb begin
    tick   = en & pix_en;
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_next = hcount;
    v_next = vcount;
    if (tick) begin
      if (h_wrap) begin
        h_next = '0;
        v_next = v_wrap ? '0 : vcount + 10'd1;
      end else begin
        h_next = hcount + 10'd1;
      end
    end
    line_end  = tick & h_wrap;
    frame_end = tick & h_wrap & v_wrap;
  end

  // video_on is computed from the next counts so it lines up with the registered position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount   <= '0;
      vcount   <= '0;
      video_on <= 1'b0;
    end else if (en) begin
      hcount   <= h_next;
      vcount   <= v_next;
      video_on <= (h_next < H_VIS) && (v_next < V_VIS);
    end
  end

`ifdef VGA_CLKDIV_EN
  // pix_en trails the phase bit by one clk so the first edge after reset yields 0.
  logic div_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_phase <= 1'b0;
      pix_en    <= 1'b0;
    end else if (en) begin
      div_phase <= ~div_phase;
      pix_en    <= div_phase;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en <= 1'b0;
    end else if (en) begin
      pix_en <= 1'b1;
    end
  end
`endif

endmodule
